// File: rtl/nspi_pkg.sv
// -----------------------------------------------------------------------------
// nspi_pkg
//
// Types and helpers shared by the nSPI transmit path (nspi_frame_feeder,
// nspi_tx) and their benches, so every user agrees on the word type and on
// the sequencing states of the frame feeder.
//
// Contents:
//   SPI_WORD_SIZE   default bits per SPI word
//   spi_word_t      one SPI word on one channel
//   feeder_state_t  frame feeder sequencing states
//   addr_width()    counter width for a given depth (never below 1 bit)
// -----------------------------------------------------------------------------
package nspi_pkg;

  localparam int SPI_WORD_SIZE = 8;

  typedef logic [SPI_WORD_SIZE-1:0] spi_word_t;

  // Explicit encodings keep the state values stable for anything that
  // decodes the state register from a waveform or a debug port.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    WAIT_TX = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } feeder_state_t;

  // Bits needed to index 0..depth-1. A depth of 1 or 2 still gets one bit so
  // that no zero-width vector is ever declared.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nspi_frame_feeder.sv
// -----------------------------------------------------------------------------
// nspi_frame_feeder
//
// Upstream stage of nspi_tx. On frame_start it walks the per-channel frame
// buffer word by word: read the word, present it on data_out, pulse start_tx,
// then wait for tx_finish before moving on. After the last word it idles for
// GAP_CYCLES so the LED matrices latch the frame, then pulses frame_done.
//
// Parameters:
//   CHANNEL_NUMBER   parallel SPI channels
//   SPI_SIZE         bits per SPI word
//   BYTES_PER_FRAME  words per channel per frame (>= 1)
//   GAP_CYCLES       idle cycles between the last tx_finish and frame_done
//   ADDR_W           derived buffer address width; leave at its default
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   frame_start  request one frame; accepted only when idle
//   busy         high whenever a frame is in progress (every state but IDLE)
//   frame_done   one-cycle pulse at the end of a frame
//   overrun      sticky flag: frame_start arrived while busy
//   rd_en        buffer read strobe
//   rd_addr      word index into the buffer
//   rd_data      buffer output, valid one cycle after rd_en
//   start_tx     one-cycle pulse to nspi_tx
//   tx_finish    one-cycle completion pulse from nspi_tx
//   data_out     word set for nspi_tx, stable from start_tx until tx_finish
//
// Timing, with frame_start sampled at edge E0:
//   E0..E1  FETCH    rd_en high
//   E1..E2  CAPTURE  rd_data becomes valid
//   E2..E3  WAIT_TX  start_tx high, data_out loaded
// An accepted tx_finish re-enters FETCH, so the next start_tx follows the
// tx_finish sampling edge by exactly two cycles.
// -----------------------------------------------------------------------------
module nspi_frame_feeder
  import nspi_pkg::*;
#(
  parameter int CHANNEL_NUMBER  = 2,
  parameter int SPI_SIZE        = 8,
  parameter int BYTES_PER_FRAME = 384,
  parameter int GAP_CYCLES      = 64,
  parameter int ADDR_W          = addr_width(BYTES_PER_FRAME)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     frame_start,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic                                     overrun,
  output logic                                     rd_en,
  output logic [ADDR_W-1:0]                        rd_addr,
  input  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  rd_data,
  output logic                                     start_tx,
  input  logic                                     tx_finish,
  output logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  data_out
);

  // Width of the gap down-counter: it only ever holds GAP_CYCLES-1..0.
  localparam int GAP_W = addr_width(GAP_CYCLES);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  feeder_state_t    state;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_word;
  logic             tx_accept;

  assign last_word = (rd_addr == LAST_ADDR);

  // start_tx is high during the first WAIT_TX cycle, so gating on it drops a
  // tx_finish that coincides with the start pulse: nspi_tx cannot have
  // finished a word it has not yet been told to send.
  assign tx_accept = (state == WAIT_TX) && tx_finish && !start_tx;

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      start_tx   <= 1'b0;
      data_out   <= '0;
      gap_cnt    <= '0;
    end else begin
      // NOTE: the one-cycle strobes default low here and are raised only by
      // the branch that needs them, so no state has to remember to clear them.
      rd_en      <= 1'b0;
      start_tx   <= 1'b0;
      frame_done <= 1'b0;

      // DONE still counts as busy, so a request in that cycle is an overrun.
      if (frame_start && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            rd_addr <= '0;
            rd_en   <= 1'b1;
          end
        end

        // rd_en is high for exactly this cycle; the buffer answers next cycle.
        FETCH: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          data_out <= rd_data;
          start_tx <= 1'b1;
          state    <= WAIT_TX;
        end

        WAIT_TX: begin
          if (tx_accept) begin
            if (last_word) begin
              if (GAP_CYCLES == 0) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              // rd_addr stops at LAST_ADDR and is only cleared by a new frame,
              // so it never wraps inside a frame.
              rd_addr <= rd_addr + 1'b1;
              rd_en   <= 1'b1;
              state   <= FETCH;
            end
          end
        end

        // Loaded with GAP_CYCLES-1 and left on reaching 0: GAP_CYCLES cycles.
        GAP: begin
          if (gap_cnt == '0) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nspi_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_nspi_frame_feeder
//
// Two feeders share one clock and reset:
//   instance 0: BYTES_PER_FRAME=4, GAP_CYCLES=3, buffer ch0=0x10+i, ch1=0x20+i
//   instance 1: BYTES_PER_FRAME=1, GAP_CYCLES=0, buffer {ch0=0xBB, ch1=0xF0}
// A behavioural model predicts every output from event times: a frame
// accepted at edge E starts its first word at E+2, an accepted tx_finish at
// edge F starts the next word at F+2 or raises frame_done at F+GAP, and busy
// falls one edge after frame_done. A compare process checks both instances
// every cycle; directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_nspi_frame_feeder;
  import nspi_pkg::*;

  localparam int N_A = 4;
  localparam int G_A = 3;
  localparam int N_B = 1;
  localparam int G_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       frame_start [2] = '{1'b0, 1'b0};
  logic       tx_auto     [2] = '{1'b0, 1'b0};
  logic       tx_inj      [2] = '{1'b0, 1'b0};
  logic       tx_finish   [2];
  logic       busy        [2];
  logic       frame_done  [2];
  logic       overrun     [2];
  logic       rd_en       [2];
  logic       start_tx    [2];
  logic [1:0][7:0] rd_data  [2];
  logic [1:0][7:0] data_out [2];
  logic [1:0] rd_addr_a;
  logic [0:0] rd_addr_b;
  int         rd_addr [2];

  assign tx_finish[0] = tx_auto[0] | tx_inj[0];
  assign tx_finish[1] = tx_auto[1] | tx_inj[1];
  assign rd_addr[0]   = int'(rd_addr_a);
  assign rd_addr[1]   = int'(rd_addr_b);

  nspi_frame_feeder #(
    .CHANNEL_NUMBER(2), .SPI_SIZE(8), .BYTES_PER_FRAME(N_A), .GAP_CYCLES(G_A)
  ) dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start[0]), .busy(busy[0]),
    .frame_done(frame_done[0]), .overrun(overrun[0]), .rd_en(rd_en[0]),
    .rd_addr(rd_addr_a), .rd_data(rd_data[0]), .start_tx(start_tx[0]),
    .tx_finish(tx_finish[0]), .data_out(data_out[0])
  );

  nspi_frame_feeder #(
    .CHANNEL_NUMBER(2), .SPI_SIZE(8), .BYTES_PER_FRAME(N_B), .GAP_CYCLES(G_B)
  ) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start[1]), .busy(busy[1]),
    .frame_done(frame_done[1]), .overrun(overrun[1]), .rd_en(rd_en[1]),
    .rd_addr(rd_addr_b), .rd_data(rd_data[1]), .start_tx(start_tx[1]),
    .tx_finish(tx_finish[1]), .data_out(data_out[1])
  );

  // ---------------------------------------------------------------- helpers
  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;
  int cyc      = 0;   // number of rising edges seen so far

  function automatic int nwords(input int i);
    return (i == 0) ? N_A : N_B;
  endfunction

  function automatic int ngap(input int i);
    return (i == 0) ? G_A : G_B;
  endfunction

  function automatic logic [15:0] buf_word(input int i, input int idx);
    spi_word_t c0, c1;
    if (i == 0) begin
      c0 = spi_word_t'(8'h10 + idx);
      c1 = spi_word_t'(8'h20 + idx);
    end else begin
      c0 = 8'hBB;
      c1 = 8'hF0;
    end
    return {c1, c0};
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // All stimulus changes 1 time unit after a falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    frame_start[i] = 1'b1;
    step();
    frame_start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (frame_done[i]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: frame_done not seen within %0d cycles", tag, budget);
    end
  endtask

  // ------------------------------------------------------- frame buffer model
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst)           rd_data[i] <= '0;
      else if (rd_en[i]) rd_data[i] <= buf_word(i, rd_addr[i]);
    end
  end

  // ------------------------------------------------ nspi_tx responders
  int tx_delay [2] = '{12, 12};
  bit resp_en  [2] = '{1'b1, 1'b1};

  always begin : resp_a
    @(negedge clk);
    if (start_tx[0] && resp_en[0]) begin
      repeat (tx_delay[0] - 1) @(negedge clk);
      #1 tx_auto[0] = 1'b1;
      @(negedge clk);
      #1 tx_auto[0] = 1'b0;
    end
  end

  always begin : resp_b
    @(negedge clk);
    if (start_tx[1] && resp_en[1]) begin
      repeat (tx_delay[1] - 1) @(negedge clk);
      #1 tx_auto[1] = 1'b1;
      @(negedge clk);
      #1 tx_auto[1] = 1'b0;
    end
  end

  // ------------------------------------------------------ behavioural model
  int          m_busy  [2];
  int          m_idx   [2];
  int          m_start [2];   // edge after which start_tx is expected
  int          m_done  [2];   // edge after which frame_done is expected
  int          m_wait  [2];
  int          m_ovr   [2];
  logic [15:0] m_dout  [2];

  task automatic model_reset(input int i);
    m_busy[i]  = 0;
    m_idx[i]   = 0;
    m_start[i] = -100;
    m_done[i]  = -100;
    m_wait[i]  = 0;
    m_ovr[i]   = 0;
    m_dout[i]  = '0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      bit acc;
      if (rst) begin
        model_reset(i);
      end else begin
        // tx_finish counts only while waiting, and not in the start_tx cycle.
        acc = (m_wait[i] != 0) && (tx_finish[i] === 1'b1) &&
              (cyc >= m_start[i] + 2);
        if (frame_start[i] === 1'b1) begin
          if (m_busy[i] != 0) begin
            m_ovr[i] = 1;
          end else begin
            m_busy[i]  = 1;
            m_idx[i]   = 0;
            m_start[i] = cyc + 2;
            m_done[i]  = -100;
            m_wait[i]  = 0;
          end
        end
        if (acc) begin
          m_wait[i] = 0;
          if (m_idx[i] == nwords(i) - 1) begin
            m_done[i] = cyc + ngap(i);
          end else begin
            m_idx[i]   = m_idx[i] + 1;
            m_start[i] = cyc + 2;
          end
        end
        if (cyc == m_start[i]) begin
          m_wait[i] = 1;
          m_dout[i] = buf_word(i, m_idx[i]);
        end
        if (cyc == m_done[i] + 1) m_busy[i] = 0;
      end
    end
  end

  // --------------------------------------------------------- compare process
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy[i] != 0));
        check($sformatf("rd_en[%0d]", i), 32'(rd_en[i]),
              32'((m_busy[i] != 0) && (cyc == m_start[i] - 2)));
        check($sformatf("rd_addr[%0d]", i), 32'(rd_addr[i]), 32'(m_idx[i]));
        check($sformatf("start_tx[%0d]", i), 32'(start_tx[i]),
              32'((m_busy[i] != 0) && (cyc == m_start[i])));
        check($sformatf("frame_done[%0d]", i), 32'(frame_done[i]),
              32'(cyc == m_done[i]));
        check($sformatf("overrun[%0d]", i), 32'(overrun[i]), 32'(m_ovr[i] != 0));
        check($sformatf("data_out[%0d]", i), 32'(data_out[i]), 32'(m_dout[i]));
      end
    end
  end

  // ---------------------------------------- event monitors for literal checks
  int          a_st_cyc [$];
  logic [15:0] a_st_dat [$];
  int          a_tf_cyc [$];
  int          a_fd_cyc [$];
  int          b_st_cnt;
  logic [15:0] b_st_dat;
  int          b_tf_cyc;
  int          b_fd_cyc;

  // A pulse seen at a falling edge was sampled by the DUT at edge cyc.
  always @(negedge clk) begin
    if (chk_on) begin
      if (start_tx[0]) begin
        a_st_cyc.push_back(cyc);
        a_st_dat.push_back(data_out[0]);
      end
      if (tx_auto[0])    a_tf_cyc.push_back(cyc);
      if (frame_done[0]) a_fd_cyc.push_back(cyc);
      if (start_tx[1]) begin
        b_st_cnt = b_st_cnt + 1;
        b_st_dat = data_out[1];
      end
      if (tx_auto[1])    b_tf_cyc = cyc;
      if (frame_done[1]) b_fd_cyc = cyc;
    end
  end

  task automatic clear_a();
    a_st_cyc.delete();
    a_st_dat.delete();
    a_tf_cyc.delete();
    a_fd_cyc.delete();
  endtask

  // Pulse count, word contents and start-to-start spacing of the last frame.
  task automatic check_frame_a(input string tag, input int spacing);
    check({tag, " pulse count"}, 32'(a_st_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < a_st_dat.size())
        check($sformatf("%s word %0d", tag, k), 32'(a_st_dat[k]),
              32'(16'h2010 + 16'h0101 * k));
      if (k > 0 && k < a_st_cyc.size())
        check($sformatf("%s spacing %0d", tag, k),
              32'(a_st_cyc[k] - a_st_cyc[k-1]), 32'(spacing));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    @(posedge clk);
    chk_on = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // 1. reset state, then reset asserted in the middle of a frame
    check("reset busy", 32'(busy[0]), 32'd0);
    check("reset data_out", 32'(data_out[0]), 32'd0);
    pulse_start(0);
    repeat (20) step();   // second word in flight
    check("mid-frame busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    step();
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort data_out", 32'(data_out[0]), 32'd0);
    check("abort rd_addr", 32'(rd_addr[0]), 32'd0);
    step();
    rst = 1'b0;
    repeat (25) step();   // stale tx_finish from the aborted word lands in IDLE
    check("idle after abort", 32'(busy[0]), 32'd0);

    // 2. nominal frame: 4 words, tx_finish 12 cycles after each start_tx
    clear_a();
    pulse_start(0);
    check("first fetch rd_en", 32'(rd_en[0]), 32'd1);
    check("first fetch rd_addr", 32'(rd_addr[0]), 32'd0);
    wait_done(0, 200, "nominal");
    check_frame_a("nominal", 14);
    if (a_tf_cyc.size() > 0 && a_fd_cyc.size() > 0)
      check("gap to frame_done", 32'(a_fd_cyc[0] - a_tf_cyc[a_tf_cyc.size()-1]), 32'd3);
    else
      check("gap events recorded", 32'(a_tf_cyc.size() * a_fd_cyc.size()), 32'd1);

    // 6. back-to-back: request in the cycle right after frame_done
    step();
    check("busy after frame", 32'(busy[0]), 32'd0);
    clear_a();
    pulse_start(0);
    wait_done(0, 200, "back-to-back");
    check_frame_a("back-to-back", 14);
    check("back-to-back overrun", 32'(overrun[0]), 32'd0);

    // 3. overrun: request during WAIT_TX
    step();
    clear_a();
    pulse_start(0);
    repeat (5) step();
    pulse_start(0);
    check("overrun set", 32'(overrun[0]), 32'd1);
    wait_done(0, 200, "overrun");
    check_frame_a("overrun", 14);
    step();
    check("overrun sticky", 32'(overrun[0]), 32'd1);

    // 4. handshake: slow tx_finish plus stray tx_finish pulses
    tx_delay[0] = 50;
    step();
    clear_a();
    pulse_start(0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (start_tx[0]) seen = 1'b1;
        else step();
      end
      check("first start_tx seen", 32'(seen), 32'd1);
    end
    tx_inj[0] = 1'b1;     // coincides with the start_tx cycle
    step();
    tx_inj[0] = 1'b0;
    wait_done(0, 400, "handshake");
    check_frame_a("handshake", 52);
    step();
    step();
    tx_inj[0] = 1'b1;     // while idle
    step();
    tx_inj[0] = 1'b0;
    step();
    check("idle tx_finish busy", 32'(busy[0]), 32'd0);
    check("idle tx_finish rd_en", 32'(rd_en[0]), 32'd0);
    tx_delay[0] = 12;

    // 5. one-word frame with no gap on instance 1
    b_st_cnt = 0;
    b_tf_cyc = -1;
    b_fd_cyc = -2;
    pulse_start(1);
    wait_done(1, 100, "single word");
    check("single pulse count", 32'(b_st_cnt), 32'd1);
    check("single word data", 32'(b_st_dat), 32'h0000_F0BB);
    // frame_done rises at the very edge that samples tx_finish
    check("single frame_done edge", 32'(b_fd_cyc - b_tf_cyc), 32'd0);
    check("single rd_addr", 32'(rd_addr[1]), 32'd0);
    step();
    check("single busy after", 32'(busy[1]), 32'd0);

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nspi_frame_feeder.md
Name: nspi_frame_feeder

Overview:
Upstream stage of nspi_tx. Walks a per-channel byte buffer (one frame of LED matrix data per channel), presents each byte set on data_out and pulses start_tx. It waits for tx_finish before the next byte. After the last byte it holds an idle gap so the matrices latch the frame, then pulses frame_done.

Parameters:
CHANNEL_NUMBER, 2, parallel SPI channels (matches nspi_tx)
SPI_SIZE, 8, bits per SPI word (matches nspi_tx)
BYTES_PER_FRAME, 384, words per channel per frame (16x8 RGB); must be >= 1
GAP_CYCLES, 64, idle clk cycles after the last tx_finish before frame_done; 0 allowed
ADDR_W, $clog2(BYTES_PER_FRAME) (min 1), derived; do not override

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_start  in  1  request one frame; sampled only in IDLE
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at frame end
overrun  out  1  sticky; set when frame_start is seen while busy; cleared only by rst
rd_en  out  1  buffer read strobe
rd_addr  out  ADDR_W  word index into the buffer
rd_data  in  [CHANNEL_NUMBER-1:0][SPI_SIZE]  buffer output, valid exactly 1 cycle after rd_en
start_tx  out  1  one-cycle pulse to nspi_tx
tx_finish  in  1  one-cycle completion pulse from nspi_tx
data_out  out  [CHANNEL_NUMBER-1:0][SPI_SIZE]  to nspi_tx data_in; held stable from start_tx until tx_finish

Behaviour:
- All outputs are registered. On rst: state IDLE, busy 0, frame_done 0, overrun 0, rd_en 0, rd_addr 0, start_tx 0, data_out all 0.
- Reset is asserted asynchronously and released on the next clk edge; mid-frame reset aborts with no frame_done.
- FSM states: IDLE, FETCH, CAPTURE, WAIT_TX, GAP, DONE.
- IDLE: frame_start=1 -> FETCH; set rd_addr=0.
- FETCH: rd_en=1 for one cycle -> CAPTURE.
- CAPTURE: load data_out<=rd_data, pulse start_tx for one cycle -> WAIT_TX.
- Latency: frame_start is sampled at edge E0; rd_en is high in cycle E0..E1; start_tx is high in cycle E2..E3.
- WAIT_TX: tx_finish is sampled only from the cycle after start_tx onward.
  - If tx_finish and rd_addr == BYTES_PER_FRAME-1: go to GAP, or to DONE if GAP_CYCLES == 0.
  - Otherwise: rd_addr++ -> FETCH.
- Back-to-back words: tx_finish to the next start_tx is exactly 2 cycles.
- GAP: the counter loads GAP_CYCLES-1 and counts down to 0 -> DONE. Exactly GAP_CYCLES cycles are spent in GAP.
- DONE: frame_done=1 for one cycle -> IDLE; busy drops in the same transition.
- tx_finish outside WAIT_TX is ignored. A tx_finish coincident with the start_tx cycle is ignored.
- frame_start in any non-IDLE state is ignored and sets overrun. frame_start in the DONE cycle also counts as an overrun.
- rd_addr never exceeds BYTES_PER_FRAME-1; it does not wrap within a frame and returns to 0 only on a new frame.
- data_out keeps the last frame's final word in IDLE.
- With BYTES_PER_FRAME=1: a single FETCH/CAPTURE/WAIT_TX pass.

Decomposition:
- Package nspi_pkg holds:
  - feeder_state_t enum (IDLE, FETCH, CAPTURE, WAIT_TX, GAP, DONE);
  - the spi_word_t typedef (logic [SPI_SIZE-1:0]);
  - the ADDR_W helper function;
  - shared so nspi_tx and its bench agree on the word type.
- No sub-module: the gap counter and address counter are small enough to inline. The top level instantiates this block beside nspi_tx.

Test Plan:
1. Reset: hold rst for 2 cycles, including one asserted mid-frame -> all outputs 0 and state IDLE on the next cycle; a new frame starts at rd_addr 0.
2. Nominal frame, BYTES_PER_FRAME=4, GAP_CYCLES=3, buffer ch0=0x10+i, ch1=0x20+i, tx_finish 12 cycles after each start_tx:
   - 4 start_tx pulses with data_out {0x10,0x20}..{0x13,0x23};
   - frame_done exactly 3 cycles after the 4th tx_finish is accepted; busy then 0.
3. Overrun: frame_start pulsed during WAIT_TX -> overrun=1 and stays 1; frame length unchanged (4 pulses).
4. Handshake: tx_finish delayed 50 cycles -> no second start_tx until 2 cycles after tx_finish. A tx_finish pulse injected in IDLE or in the start_tx cycle -> no state change.
5. GAP_CYCLES=0, BYTES_PER_FRAME=1, data {0xBB,0xF0} -> one start_tx; frame_done 1 cycle after tx_finish; rd_addr stays 0.
6. Back-to-back: frame_start again in the cycle after frame_done -> second frame runs with an identical pulse sequence; overrun remains 0.
